control_sequencer: RTL and testbench
====================================

# control_sequencer

Microprogrammed control unit that drives the select lines of the datapath multiplexers (A, PB, C, D, E, J) plus register-file, IR, MAR and MDR load strobes. It sequences instruction fetch, decode and execute for data-processing, single load/store, B and BL. It handles the memory MOV/MOC handshake and traps a stalled memory in a sticky fault state. It sits directly upstream of the mux bank and consumes IR, the condition-tester result and the memory handshake.

## Interface
- TIMEOUT, 15, cycles a wait state may hold MOV high without MOC before FAULT (1..15)
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous, active-low reset
- ir  in  32  current instruction register
- cond_true  in  1  condition field satisfied by current flags
- moc  in  1  memory operation complete
- MA  out  2 / MB  out  2 / MC  out  3 / MD  out  1 / ME  out  1 / MJ  out  2  mux selects
- op  out  5  ALU opcode presented on the MD=1 path
- rf_ld, ir_ld, mar_ld, mdr_ld, cc_ld  out  1  load strobes
- mov  out  1  memory operation valid; rw  out  1  1=read, 0=write
- fault  out  1  memory timeout trap
- state  out  4  current state code

## Operation
- Opcodes: ADD 5'b00100, SUB 5'b00010, MOV (pass B) 5'b01101, PASSA 5'b10000.
- Moore outputs are decoded from the state register only, except the gated strobes below. Unlisted outputs are 0.
- States and transitions:
  - 0 RESET: goes to 1.
  - 1 FETCH_A: MA=2, MD=1, op=PASSA, mar_ld=1. Goes to 2.
  - 2 FETCH_B: MA=2, MB=3 (increment constant), MD=1, op=ADD, MC=3, rf_ld=1. Goes to 3.
  - 3 FETCH_W: mov=1, rw=1, ir_ld=moc. On moc goes to 4.
  - 4 DECODE:
    - !cond_true goes to 1.
    - ir[27:25]=000/001 goes to 5.
    - ir[27:25]=010 goes to 6.
    - ir[27:25]=101 goes to 12 if ir[24], else 10.
    - Any other value goes to 1 (NOP).
  - 5 DP_EXEC: MA=0, MB=1, MD=0, MC=0, rf_ld=(ir[24:23]!=2'b10), cc_ld=ir[20]. Goes to 1.
  - 6 MEM_ADDR: MA=0, MB=1, MD=1, op=ir[23]?ADD:SUB, mar_ld=1. Goes to 7 if ir[20], else 8.
  - 7 LDR_W: mov=1, rw=1, ME=0, mdr_ld=moc. On moc goes to 9.
  - 8 STR_DATA: MJ=2, MB=0, MD=1, op=MOV, ME=1, mdr_ld=1. Goes to 11.
  - 9 LDR_WB: MB=2, MD=1, op=MOV, MC=0, rf_ld=1. Goes to 1.
  - 10 BRANCH: MA=2, MB=1, MD=1, op=ADD, MC=3, rf_ld=1. Goes to 1.
  - 11 STR_W: mov=1, rw=0. On moc goes to 1.
  - 12 LINK: MA=2, MD=1, op=PASSA, MC=2, rf_ld=1. Goes to 10.
  - 13 FAULT: fault=1, all strobes 0. Absorbing until reset.
  - 14 and 15 are illegal and go to 0.
- Watchdog:
  - 4-bit counter, cleared on entry to any wait state (3, 7, 11).
  - Increments each cycle spent in that wait state with moc=0.
  - If the counter equals TIMEOUT-1 and moc=0, the next state is 13.
  - moc=1 always takes priority over timeout in the same cycle.
- moc sampled outside a wait state is ignored.

## Timing
- Reset: state=0 asynchronously. Every output reads 0 during reset, and MA..MJ are 0.
- One state per clk edge.
- Minimum instruction lengths, each including fetch with moc already high:
  - Data processing: 5 cycles.
  - NOP or failed condition: 4 cycles.
  - LDR: 7 cycles.
  - STR: 7 cycles.
  - B: 5 cycles.
  - BL: 6 cycles.
- ir_ld and mdr_ld in wait states are combinational on moc, so the load happens on the same edge that leaves the state.
- mov rises in the first cycle of a wait state and holds until the edge where moc=1 is sampled.
- Deassertion of rst_n mid-instruction abandons the instruction. The first post-reset edge enters FETCH_A.

## Structure
- Shared package `cpu_ctrl_pkg`:
  - State encoding constants.
  - ALU opcode constants.
  - Mux-select constants: MA_RN=0, MA_PC=2, MB_REG=0, MB_SHIFT=1, MB_MDR=2, MB_CONST=3, MC_RD=0, MC_LR=2, MC_PC=3, MJ_RM=0, MJ_RD=2.
- Sub-module `mem_watchdog`: counter, clear/enable inputs, `expired` output. The rest is one state register plus a combinational output decoder.

## Test plan
- Reset with moc=1, ir=32'hE0812003 (ADD, cond AL), cond_true=1:
  - state sequence 0,1,2,3,4,5,1.
  - In state 5: rf_ld=1, MA=0, MC=0, MD=0.
- ir=32'hE1510002 (CMP, S=1):
  - In state 5: rf_ld=0, cc_ld=1.
- ir=32'hE5912004 (LDR, U=1) with moc low for 3 cycles in state 7:
  - mov held 4 cycles, op=ADD in state 6.
  - mdr_ld pulses only on the exit edge.
  - state 9 shows MB=2, rf_ld=1.
- ir=32'hEB000010 (BL):
  - states 4,12,10,1.
  - In state 12: MC=2, op=PASSA.
  - In state 10: MC=3, op=ADD.
- cond_true=0 after fetch: state 4 goes to 1, with no rf_ld or cc_ld pulse.
- moc held 0 in state 11 with TIMEOUT=15:
  - state 13 after 15 cycles, fault=1 and sticky.
  - A later moc=1 keeps state 13.
  - rst_n low clears to 0 immediately.

Source files
------------

// File: rtl/cpu_ctrl_pkg.sv
// Shared definitions for the microprogrammed control sequencer: state
// encoding, ALU opcodes driven on the MD=1 path and datapath mux selects.
package cpu_ctrl_pkg;

   typedef enum logic [3:0] {
      S_RESET    = 4'd0,
      S_FETCH_A  = 4'd1,
      S_FETCH_B  = 4'd2,
      S_FETCH_W  = 4'd3,
      S_DECODE   = 4'd4,
      S_DP_EXEC  = 4'd5,
      S_MEM_ADDR = 4'd6,
      S_LDR_W    = 4'd7,
      S_STR_DATA = 4'd8,
      S_LDR_WB   = 4'd9,
      S_BRANCH   = 4'd10,
      S_STR_W    = 4'd11,
      S_LINK     = 4'd12,
      S_FAULT    = 4'd13
   } state_t;

   localparam logic [4:0] OP_ADD   = 5'b00100;
   localparam logic [4:0] OP_SUB   = 5'b00010;
   localparam logic [4:0] OP_MOV   = 5'b01101;
   localparam logic [4:0] OP_PASSA = 5'b10000;

   localparam logic [1:0] MA_RN    = 2'd0;
   localparam logic [1:0] MA_PC    = 2'd2;
   localparam logic [1:0] MB_REG   = 2'd0;
   localparam logic [1:0] MB_SHIFT = 2'd1;
   localparam logic [1:0] MB_MDR   = 2'd2;
   localparam logic [1:0] MB_CONST = 2'd3;
   localparam logic [2:0] MC_RD    = 3'd0;
   localparam logic [2:0] MC_LR    = 3'd2;
   localparam logic [2:0] MC_PC    = 3'd3;
   localparam logic [1:0] MJ_RM    = 2'd0;
   localparam logic [1:0] MJ_RD    = 2'd2;

   // States that hold MOV high while waiting for MOC.
   function automatic logic is_wait(input state_t s);
      return (s == S_FETCH_W) || (s == S_LDR_W) || (s == S_STR_W);
   endfunction

endpackage

// File: rtl/mem_watchdog.sv
// Counts cycles a wait state spends without MOC and flags the cycle after
// which the memory is considered stalled.
module mem_watchdog
   import cpu_ctrl_pkg::*;
#(
   parameter int unsigned TIMEOUT = 15
)(
   input  logic clk,
   input  logic rst_n,
   input  logic clr,
   input  logic en,
   output logic expired
);

   localparam logic [3:0] LAST = 4'(TIMEOUT - 1);

   logic [3:0] cnt_r;

   // Stall counter: held at zero outside wait states, counts idle wait cycles.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_r <= 4'd0;
      end else if (clr) begin
         cnt_r <= 4'd0;
      end else if (en) begin
         cnt_r <= cnt_r + 4'd1;
      end else begin
         cnt_r <= cnt_r;
      end
   end

   assign expired = en && (cnt_r == LAST);

endmodule

// File: rtl/control_sequencer.sv
// Control sequencer: fetch / decode / execute for data processing, LDR/STR,
// B and BL, driving datapath mux selects and load strobes, with a sticky
// trap when memory never answers.
module control_sequencer
   import cpu_ctrl_pkg::*;
#(
   parameter int unsigned TIMEOUT = 15
)(
   input  logic        clk,
   input  logic        rst_n,
   input  logic [31:0] ir,
   input  logic        cond_true,
   input  logic        moc,
   output logic [1:0]  MA,
   output logic [1:0]  MB,
   output logic [2:0]  MC,
   output logic        MD,
   output logic        ME,
   output logic [1:0]  MJ,
   output logic [4:0]  op,
   output logic        rf_ld,
   output logic        ir_ld,
   output logic        mar_ld,
   output logic        mdr_ld,
   output logic        cc_ld,
   output logic        mov,
   output logic        rw,
   output logic        fault,
   output logic [3:0]  state
);

   state_t state_r;
   state_t state_nxt_s;
   logic   in_wait_s;
   logic   wd_en_s;
   logic   wd_expired_s;
   logic   unused_ir_s;

   assign in_wait_s   = is_wait(state_r);
   assign wd_en_s     = in_wait_s && !moc;
   assign state       = state_r;
   assign unused_ir_s = ^{ir[31:28], ir[22:21], ir[19:0]};

   mem_watchdog #(.TIMEOUT(TIMEOUT)) u_wd (
      .clk     (clk),
      .rst_n   (rst_n),
      .clr     (!in_wait_s),
      .en      (wd_en_s),
      .expired (wd_expired_s)
   );

   // Next-state logic; in wait states MOC beats the watchdog.
   always_comb begin
      state_nxt_s = S_RESET;
      case (state_r)
         S_RESET:    state_nxt_s = S_FETCH_A;
         S_FETCH_A:  state_nxt_s = S_FETCH_B;
         S_FETCH_B:  state_nxt_s = S_FETCH_W;
         S_FETCH_W: begin
            if (moc)               state_nxt_s = S_DECODE;
            else if (wd_expired_s) state_nxt_s = S_FAULT;
            else                   state_nxt_s = S_FETCH_W;
         end
         S_DECODE: begin
            if (!cond_true) begin
               state_nxt_s = S_FETCH_A;
            end else begin
               case (ir[27:25])
                  3'b000, 3'b001: state_nxt_s = S_DP_EXEC;
                  3'b010:         state_nxt_s = S_MEM_ADDR;
                  3'b101:         state_nxt_s = ir[24] ? S_LINK : S_BRANCH;
                  default:        state_nxt_s = S_FETCH_A;
               endcase
            end
         end
         S_DP_EXEC:  state_nxt_s = S_FETCH_A;
         S_MEM_ADDR: state_nxt_s = ir[20] ? S_LDR_W : S_STR_DATA;
         S_LDR_W: begin
            if (moc)               state_nxt_s = S_LDR_WB;
            else if (wd_expired_s) state_nxt_s = S_FAULT;
            else                   state_nxt_s = S_LDR_W;
         end
         S_STR_DATA: state_nxt_s = S_STR_W;
         S_LDR_WB:   state_nxt_s = S_FETCH_A;
         S_BRANCH:   state_nxt_s = S_FETCH_A;
         S_STR_W: begin
            if (moc)               state_nxt_s = S_FETCH_A;
            else if (wd_expired_s) state_nxt_s = S_FAULT;
            else                   state_nxt_s = S_STR_W;
         end
         S_LINK:     state_nxt_s = S_BRANCH;
         S_FAULT:    state_nxt_s = S_FAULT;
         default:    state_nxt_s = S_RESET;
      endcase
   end

   // State register; reset abandons any instruction in flight.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r <= S_RESET;
      end else begin
         state_r <= state_nxt_s;
      end
   end

   // Output decoder from the state register; only ir_ld/mdr_ld in waits follow moc.
   always_comb begin
      MA = MA_RN;  MB = MB_REG;  MC = MC_RD;  MD = 1'b0;  ME = 1'b0;  MJ = MJ_RM;
      op = 5'b00000;
      rf_ld = 1'b0;  ir_ld = 1'b0;  mar_ld = 1'b0;  mdr_ld = 1'b0;  cc_ld = 1'b0;
      mov = 1'b0;  rw = 1'b0;  fault = 1'b0;
      case (state_r)
         S_FETCH_A: begin
            MA = MA_PC;  MD = 1'b1;  op = OP_PASSA;  mar_ld = 1'b1;
         end
         S_FETCH_B: begin
            MA = MA_PC;  MB = MB_CONST;  MD = 1'b1;  op = OP_ADD;  MC = MC_PC;  rf_ld = 1'b1;
         end
         S_FETCH_W: begin
            mov = 1'b1;  rw = 1'b1;  ir_ld = moc;
         end
         S_DP_EXEC: begin
            MA = MA_RN;  MB = MB_SHIFT;  MD = 1'b0;  MC = MC_RD;
            rf_ld = (ir[24:23] != 2'b10);
            cc_ld = ir[20];
         end
         S_MEM_ADDR: begin
            MA = MA_RN;  MB = MB_SHIFT;  MD = 1'b1;  mar_ld = 1'b1;
            op = ir[23] ? OP_ADD : OP_SUB;
         end
         S_LDR_W: begin
            mov = 1'b1;  rw = 1'b1;  ME = 1'b0;  mdr_ld = moc;
         end
         S_STR_DATA: begin
            MJ = MJ_RD;  MB = MB_REG;  MD = 1'b1;  op = OP_MOV;  ME = 1'b1;  mdr_ld = 1'b1;
         end
         S_LDR_WB: begin
            MB = MB_MDR;  MD = 1'b1;  op = OP_MOV;  MC = MC_RD;  rf_ld = 1'b1;
         end
         S_BRANCH: begin
            MA = MA_PC;  MB = MB_SHIFT;  MD = 1'b1;  op = OP_ADD;  MC = MC_PC;  rf_ld = 1'b1;
         end
         S_STR_W: begin
            mov = 1'b1;  rw = 1'b0;
         end
         S_LINK: begin
            MA = MA_PC;  MD = 1'b1;  op = OP_PASSA;  MC = MC_LR;  rf_ld = 1'b1;
         end
         S_FAULT: begin
            fault = 1'b1;
         end
         default: begin
            fault = 1'b0;
         end
      endcase
   end

endmodule

// File: tb/tb_control_sequencer.sv
// Directed bench: each cycle the stimulus pushes the expected observation,
// and a negedge monitor pops and compares it against the DUT.
module tb_control_sequencer;

   typedef struct packed {
      logic [3:0] st;
      logic [1:0] ma;
      logic [1:0] mb;
      logic [2:0] mc;
      logic       md;
      logic       me;
      logic [1:0] mj;
      logic [4:0] op;
      logic       rf;
      logic       irl;
      logic       marl;
      logic       mdrl;
      logic       ccl;
      logic       mov;
      logic       rw;
      logic       flt;
   } obs_t;

   localparam logic [31:0] I_ADD = 32'hE0812003;
   localparam logic [31:0] I_CMP = 32'hE1510002;
   localparam logic [31:0] I_LDR = 32'hE5912004;
   localparam logic [31:0] I_STR = 32'hE5812004;
   localparam logic [31:0] I_BL  = 32'hEB000010;
   localparam logic [31:0] I_B   = 32'hEA000010;
   localparam logic [31:0] I_NOP = 32'hE6000000;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [31:0] ir = I_ADD;
   logic        cond_true = 1'b1;
   logic        moc = 1'b1;
   logic [1:0]  MA, MB, MJ;
   logic [2:0]  MC;
   logic        MD, ME;
   logic [4:0]  op;
   logic        rf_ld, ir_ld, mar_ld, mdr_ld, cc_ld, mov, rw, fault;
   logic [3:0]  state;

   obs_t exp_q[$];
   int   n_vec = 0;
   int   n_bad = 0;

   control_sequencer #(.TIMEOUT(15)) dut (
      .clk(clk), .rst_n(rst_n), .ir(ir), .cond_true(cond_true), .moc(moc),
      .MA(MA), .MB(MB), .MC(MC), .MD(MD), .ME(ME), .MJ(MJ), .op(op),
      .rf_ld(rf_ld), .ir_ld(ir_ld), .mar_ld(mar_ld), .mdr_ld(mdr_ld), .cc_ld(cc_ld),
      .mov(mov), .rw(rw), .fault(fault), .state(state)
   );

   always #5 clk = ~clk;

   // Expected outputs for a state, transcribed from the control table.
   function automatic obs_t spec_out(input logic [3:0] st, input logic [31:0] iv, input logic m);
      obs_t o;
      o = '0;
      o.st = st;
      case (st)
         4'd1:  begin o.ma = 2'd2; o.md = 1'b1; o.op = 5'b10000; o.marl = 1'b1; end
         4'd2:  begin o.ma = 2'd2; o.mb = 2'd3; o.md = 1'b1; o.op = 5'b00100; o.mc = 3'd3; o.rf = 1'b1; end
         4'd3:  begin o.mov = 1'b1; o.rw = 1'b1; o.irl = m; end
         4'd5:  begin o.mb = 2'd1; o.rf = (iv[24:23] != 2'b10); o.ccl = iv[20]; end
         4'd6:  begin o.mb = 2'd1; o.md = 1'b1; o.marl = 1'b1; o.op = iv[23] ? 5'b00100 : 5'b00010; end
         4'd7:  begin o.mov = 1'b1; o.rw = 1'b1; o.mdrl = m; end
         4'd8:  begin o.mj = 2'd2; o.md = 1'b1; o.op = 5'b01101; o.me = 1'b1; o.mdrl = 1'b1; end
         4'd9:  begin o.mb = 2'd2; o.md = 1'b1; o.op = 5'b01101; o.rf = 1'b1; end
         4'd10: begin o.ma = 2'd2; o.mb = 2'd1; o.md = 1'b1; o.op = 5'b00100; o.mc = 3'd3; o.rf = 1'b1; end
         4'd11: begin o.mov = 1'b1; end
         4'd12: begin o.ma = 2'd2; o.md = 1'b1; o.op = 5'b10000; o.mc = 3'd2; o.rf = 1'b1; end
         4'd13: begin o.flt = 1'b1; end
         default: begin o.st = st; end
      endcase
      return o;
   endfunction

   // One cycle of stimulus: drive inputs just after the edge and queue the expectation.
   task automatic cyc(input logic r, input logic [31:0] iv, input logic c,
                      input logic m, input logic [3:0] es);
      @(posedge clk);
      #1;
      rst_n     = r;
      ir        = iv;
      cond_true = c;
      moc       = m;
      exp_q.push_back(spec_out(es, iv, m));
   endtask

   task automatic fetch(input logic [31:0] iv, input logic c);
      cyc(1'b1, iv, c, 1'b1, 4'd1);
      cyc(1'b1, iv, c, 1'b1, 4'd2);
      cyc(1'b1, iv, c, 1'b1, 4'd3);
      cyc(1'b1, iv, c, 1'b1, 4'd4);
   endtask

   // Monitor: compare the DUT against the queued expectation mid-cycle.
   always @(negedge clk) begin
      obs_t act;
      obs_t exp_v;
      if (exp_q.size() > 0) begin
         exp_v = exp_q.pop_front();
         act = '{st: state, ma: MA, mb: MB, mc: MC, md: MD, me: ME, mj: MJ, op: op,
                 rf: rf_ld, irl: ir_ld, marl: mar_ld, mdrl: mdr_ld, ccl: cc_ld,
                 mov: mov, rw: rw, flt: fault};
         n_vec++;
         if (act !== exp_v) begin
            n_bad++;
            $display("FAIL vec%0d (state %0d): got %h required %h", n_vec, exp_v.st, act, exp_v);
         end
      end
   end

   initial begin
      // Reset held, then released away from the edge.
      cyc(1'b0, I_ADD, 1'b1, 1'b1, 4'd0);
      cyc(1'b1, I_ADD, 1'b1, 1'b1, 4'd0);
      // ADD: 1,2,3,4,5
      fetch(I_ADD, 1'b1);
      cyc(1'b1, I_ADD, 1'b1, 1'b1, 4'd5);
      // CMP with S: no rf_ld, cc_ld
      fetch(I_CMP, 1'b1);
      cyc(1'b1, I_CMP, 1'b1, 1'b1, 4'd5);
      // LDR with three idle wait cycles
      fetch(I_LDR, 1'b1);
      cyc(1'b1, I_LDR, 1'b1, 1'b1, 4'd6);
      for (int i = 0; i < 3; i++) cyc(1'b1, I_LDR, 1'b1, 1'b0, 4'd7);
      cyc(1'b1, I_LDR, 1'b1, 1'b1, 4'd7);
      cyc(1'b1, I_LDR, 1'b1, 1'b1, 4'd9);
      // BL: 4,12,10
      fetch(I_BL, 1'b1);
      cyc(1'b1, I_BL, 1'b1, 1'b1, 4'd12);
      cyc(1'b1, I_BL, 1'b1, 1'b1, 4'd10);
      // B: 4,10
      fetch(I_B, 1'b1);
      cyc(1'b1, I_B, 1'b1, 1'b1, 4'd10);
      // Undefined class decodes as NOP
      fetch(I_NOP, 1'b1);
      // Failed condition: 4 goes straight back to 1
      fetch(I_ADD, 1'b0);
      // STR completing immediately
      fetch(I_STR, 1'b1);
      cyc(1'b1, I_STR, 1'b1, 1'b1, 4'd6);
      cyc(1'b1, I_STR, 1'b1, 1'b1, 4'd8);
      cyc(1'b1, I_STR, 1'b1, 1'b1, 4'd11);
      // STR stalled: 15 idle cycles in 11, then sticky fault
      fetch(I_STR, 1'b1);
      cyc(1'b1, I_STR, 1'b1, 1'b1, 4'd6);
      cyc(1'b1, I_STR, 1'b1, 1'b1, 4'd8);
      for (int i = 0; i < 15; i++) cyc(1'b1, I_STR, 1'b1, 1'b0, 4'd11);
      cyc(1'b1, I_STR, 1'b1, 1'b0, 4'd13);
      cyc(1'b1, I_STR, 1'b1, 1'b1, 4'd13);
      cyc(1'b1, I_STR, 1'b1, 1'b1, 4'd13);
      // Asynchronous reset out of fault, then restart at FETCH_A
      cyc(1'b0, I_ADD, 1'b1, 1'b1, 4'd0);
      cyc(1'b1, I_ADD, 1'b1, 1'b1, 4'd0);
      cyc(1'b1, I_ADD, 1'b1, 1'b1, 4'd1);
      cyc(1'b1, I_ADD, 1'b1, 1'b1, 4'd2);

      repeat (2) @(negedge clk);
      #1;
      if (exp_q.size() != 0) begin
         n_vec++;
         n_bad++;
         $display("FAIL drain: %0d expectations left, required 0", exp_q.size());
      end
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
